// File: rtl/microwave_pkg.sv
// Shared types and helpers for the microwave cook-time controller.
//   timer_state_t      : controller state encoding
//   CLOSED..OPEN       : microwave oven state encodings (for benches probing the oven)
//   sat_add(a, b, tw)  : a + b clamped to 2**tw-1
package microwave_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StStart,
        StRun,
        StDone
    } timer_state_t;

    localparam logic [2:0] CLOSED = 3'd0;
    localparam logic [2:0] COOK   = 3'd1;
    localparam logic [2:0] PAUSE  = 3'd2;
    localparam logic [2:0] BELL   = 3'd3;
    localparam logic [2:0] OPEN   = 3'd4;

    // Width-generic saturating add: the caller passes its counter width in tw.
    // The sum carries one extra bit so the overflow is visible before clamping.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned tw);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << tw) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides clk down to one-second ticks of cook time.
//   clk, nrst : clock, async active-low reset
//   en        : count this cycle
//   clr       : synchronous clear (wins over en)
//   tick      : one-cycle pulse on the cycle the count wraps
module sec_prescaler #(
    parameter int unsigned TICKS_PER_SEC = 4
) (
    input  logic clk,
    input  logic nrst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] Last = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == Last) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/microwave_timer.sv
// Cook-time controller sequencing the microwave FSM.
//   clk, nrst      : clock, async active-low reset
//   add_sec        : pulse, add ADD_STEP seconds
//   clr            : pulse, cancel / zero time
//   go             : pulse, user start request
//   heat, bell     : oven status (COOK / BELL)
//   start, finish  : level requests to the oven
//   remaining      : seconds left
//   busy           : high in START, RUN, DONE
// All outputs are decoded from registered state only.
module microwave_timer
    import microwave_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 4,
    parameter int unsigned ADD_STEP      = 10,
    parameter int unsigned TW            = 8
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          add_sec,
    input  logic          clr,
    input  logic          go,
    input  logic          heat,
    input  logic          bell,
    output logic          start,
    output logic          finish,
    output logic [TW-1:0] remaining,
    output logic          busy
);

    timer_state_t  state_q, state_d;
    logic [TW-1:0] remaining_q, remaining_d;
    logic [TW-1:0] dec_val;
    logic          tick;
    logic          ps_en;
    logic          ps_clr;

    function automatic logic [TW-1:0] add_step(input logic [TW-1:0] v);
        return TW'(sat_add(32'(v), ADD_STEP, TW));
    endfunction

    // Time only advances while the oven is actually heating; the prescaler is
    // held at zero outside RUN so every run starts on a whole second.
    assign ps_en  = (state_q == StRun) & heat;
    assign ps_clr = (state_q != StRun) | clr;

    sec_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clk (clk),
        .nrst(nrst),
        .en  (ps_en),
        .clr (ps_clr),
        .tick(tick)
    );

    assign dec_val = (tick && (remaining_q != '0)) ? remaining_q - TW'(1) : remaining_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        unique case (state_q)
            StIdle: begin
                if (add_sec) begin
                    remaining_d = add_step('0);
                    state_d     = StArmed;
                end
            end
            StArmed: begin
                if (clr) begin
                    remaining_d = '0;
                    state_d     = StIdle;
                end else if (go) begin
                    state_d = StStart;
                end else if (add_sec) begin
                    remaining_d = add_step(remaining_q);
                end
            end
            StStart: begin
                if (clr) begin
                    remaining_d = '0;
                    state_d     = StIdle;
                end else begin
                    if (add_sec) begin
                        remaining_d = add_step(remaining_q);
                    end
                    if (heat) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (clr) begin
                    remaining_d = '0;
                    state_d     = StDone;
                end else if (add_sec) begin
                    // A top-up landing on the last tick keeps the run alive.
                    remaining_d = add_step(dec_val);
                end else begin
                    remaining_d = dec_val;
                    if (tick && (remaining_q == TW'(1))) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (bell) begin
                    state_d = StIdle;
                end
            end
            default: begin
                remaining_d = '0;
                state_d     = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= StIdle;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    assign start     = (state_q == StStart);
    assign finish    = (state_q == StDone);
    assign busy      = (state_q == StStart) | (state_q == StRun) | (state_q == StDone);
    assign remaining = remaining_q;

endmodule

// File: tb/tb_microwave_timer.sv
// Integration bench: microwave_timer plus a behavioural oven, with the door
// driven by the bench. Expected outputs come from a reference model counting
// heating cycles since RUN entry.
module tb_microwave_timer;
    import microwave_pkg::*;

    localparam int unsigned TPS  = 4;
    localparam int unsigned STEP = 10;
    localparam int unsigned TW   = 8;
    localparam int MaxRem = 255;
    localparam int MIdle = 0, MArmed = 1, MStart = 2, MRun = 3, MDone = 4;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic add_sec = 1'b0;
    logic clr = 1'b0;
    logic go = 1'b0;
    logic door = 1'b0;
    logic heat, bell, start, finish, busy;
    logic [TW-1:0] remaining;
    logic [2:0] oven_q;
    logic [TW+2:0] got;
    int checks = 0;
    int errors = 0;
    bit ok;

    // Reference model state and its next value.
    int m_mode, m_rem, m_hc;
    int n_mode, n_rem, n_hc;

    always #5 clk = ~clk;

    microwave_timer #(
        .TICKS_PER_SEC(TPS),
        .ADD_STEP     (STEP),
        .TW           (TW)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .add_sec  (add_sec),
        .clr      (clr),
        .go       (go),
        .heat     (heat),
        .bell     (bell),
        .start    (start),
        .finish   (finish),
        .remaining(remaining),
        .busy     (busy)
    );

    // Behavioural oven.
    assign heat = (oven_q == COOK);
    assign bell = (oven_q == BELL);
    always @(posedge clk or negedge nrst) begin
        if (!nrst) oven_q <= CLOSED;
        else begin
            case (oven_q)
                CLOSED, OPEN: oven_q <= door ? OPEN : (start ? COOK : CLOSED);
                COOK:         oven_q <= door ? PAUSE : (finish ? BELL : COOK);
                PAUSE:        oven_q <= door ? PAUSE : COOK;
                BELL:         oven_q <= door ? OPEN : CLOSED;
                default:      oven_q <= CLOSED;
            endcase
        end
    end

    function automatic int sat(input int v);
        return (v > MaxRem) ? MaxRem : v;
    endfunction

    always_comb begin
        n_mode = m_mode;
        n_rem  = m_rem;
        n_hc   = m_hc;
        case (m_mode)
            MIdle: if (add_sec) begin n_rem = STEP; n_mode = MArmed; end
            MArmed: begin
                if (clr) begin n_rem = 0; n_mode = MIdle; end
                else if (go) n_mode = MStart;
                else if (add_sec) n_rem = sat(m_rem + STEP);
            end
            MStart: begin
                if (clr) begin n_rem = 0; n_mode = MIdle; end
                else begin
                    if (add_sec) n_rem = sat(m_rem + STEP);
                    if (heat) begin n_mode = MRun; n_hc = 0; end
                end
            end
            MRun: begin
                if (clr) begin n_rem = 0; n_mode = MDone; end
                else if (heat) begin
                    n_hc = m_hc + 1;
                    // Every TPS-th heating cycle completes one second.
                    if ((n_hc % TPS) == 0 && m_rem > 0) n_rem = m_rem - 1;
                    if (add_sec) n_rem = sat(n_rem + STEP);
                    else if ((n_hc % TPS) == 0 && n_rem == 0) n_mode = MDone;
                end else if (add_sec) n_rem = sat(m_rem + STEP);
            end
            MDone: if (bell) n_mode = MIdle;
            default: n_mode = MIdle;
        endcase
    end

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_mode <= MIdle;
            m_rem  <= 0;
            m_hc   <= 0;
        end else begin
            m_mode <= n_mode;
            m_rem  <= n_rem;
            m_hc   <= n_hc;
        end
    end

    function automatic logic [TW+2:0] exp_vec();
        return {m_mode == MStart, m_mode == MDone, m_mode >= MStart, TW'(m_rem)};
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse(input logic a, input logic c, input logic g);
        add_sec = a; clr = c; go = g;
        cycle();
        add_sec = 1'b0; clr = 1'b0; go = 1'b0;
    endtask

    // Close the door and let the current run finish; ok reports reaching IDLE.
    task automatic drain(output bit done);
        door = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (m_mode == MIdle && !busy && oven_q != BELL) begin done = 1'b1; break; end
            cycle();
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        cycle();
        got = {start, finish, busy, remaining};
        checks++;
        if (got !== '0) begin errors++; $display("FAIL reset_state got=%h exp=0", got); end
        nrst = 1'b1;
        cycle();
        pulse(1'b0, 1'b0, 1'b1);
        got = {start, finish, busy, remaining};
        checks++;
        if (got !== '0) begin errors++; $display("FAIL reset_go_idle got=%h exp=0", got); end
    endtask

    task automatic test_basic_cook();
        int n, run_at, fin_at;
        n = $urandom_range(1, 3);
        run_at = -1;
        fin_at = -1;
        for (int i = 0; i < n; i++) pulse(1'b1, 1'b0, 1'b0);
        got = {start, finish, busy, remaining};
        checks++;
        if (got !== {3'b000, TW'(n * STEP)}) begin
            errors++; $display("FAIL basic_armed got=%h exp=%h", got, {3'b000, TW'(n * STEP)});
        end
        pulse(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 50 * n + 10; c++) begin
            got = {start, finish, busy, remaining};
            checks++;
            if (got !== exp_vec()) begin
                errors++; $display("FAIL basic_cycle c=%0d got=%h exp=%h", c, got, exp_vec());
            end
            if (run_at < 0 && busy && !start && !finish) run_at = c;
            if (finish) begin fin_at = c; break; end
            cycle();
        end
        checks++;
        if (fin_at < 0 || run_at < 0 || (fin_at - run_at) < 40 * n - 1
            || (fin_at - run_at) > 40 * n + 1) begin
            errors++; $display("FAIL basic_finish_latency got=%0d exp=%0d", fin_at - run_at, 40 * n);
        end
        for (int c = 0; c < 10 && finish; c++) begin
            cycle();
            got = {start, finish, busy, remaining};
            checks++;
            if (got !== exp_vec()) begin
                errors++; $display("FAIL basic_bell got=%h exp=%h", got, exp_vec());
            end
        end
        got = {start, finish, busy, remaining};
        checks++;
        if (got !== '0) begin errors++; $display("FAIL basic_idle got=%h exp=0", got); end
    endtask

    task automatic test_pause();
        int extra;
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (m_mode == MRun && m_rem == 7) begin ok = 1'b1; break; end
            cycle();
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL pause_reach7 got=%0d exp=7", remaining); end
        extra = $urandom_range(0, 2);
        for (int i = 0; i < extra; i++) cycle();
        door = 1'b1;
        for (int c = 0; c < 13; c++) begin
            cycle();
            checks++;
            if (remaining !== TW'(7) || finish !== 1'b0) begin
                errors++; $display("FAIL pause_frozen c=%0d got=%0d exp=7", c, remaining);
            end
        end
        door = 1'b0;
        for (int c = 0; c < 60 && !finish; c++) begin
            cycle();
            got = {start, finish, busy, remaining};
            checks++;
            if (got !== exp_vec()) begin
                errors++; $display("FAIL pause_resume c=%0d got=%h exp=%h", c, got, exp_vec());
            end
        end
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL pause_drain got=busy exp=idle"); end
    endtask

    task automatic test_door_open_at_go();
        door = 1'b1;
        cycle();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (start !== 1'b1 || remaining !== TW'(10) || heat !== 1'b0) begin
                errors++;
                $display("FAIL door_hold c=%0d got=%b/%0d/%b exp=1/10/0", c, start, remaining, heat);
            end
            cycle();
        end
        door = 1'b0;
        cycle();
        checks++;
        if (heat !== 1'b1) begin errors++; $display("FAIL door_heat got=%b exp=1", heat); end
        cycle();
        got = {start, finish, busy, remaining};
        checks++;
        if (got !== {3'b001, TW'(10)}) begin
            errors++; $display("FAIL door_run got=%h exp=%h", got, {3'b001, TW'(10)});
        end
        pulse(1'b0, 1'b1, 1'b0);
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL door_drain got=busy exp=idle"); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 26; i++) pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (remaining !== TW'(255)) begin
            errors++; $display("FAIL sat_255 got=%0d exp=255", remaining);
        end
        pulse(1'b1, 1'b1, 1'b0);
        got = {start, finish, busy, remaining};
        checks++;
        if (got !== '0) begin errors++; $display("FAIL sat_clr_add got=%h exp=0", got); end
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b1);
        got = {start, finish, busy, remaining};
        checks++;
        if (got !== {3'b101, TW'(20)}) begin
            errors++; $display("FAIL sat_go_beats_add got=%h exp=%h", got, {3'b101, TW'(20)});
        end
        pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (busy !== 1'b0 || remaining !== '0) begin
            errors++; $display("FAIL sat_start_clr got=%b/%0d exp=0/0", busy, remaining);
        end
    endtask

    task automatic test_tick_add();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (m_mode == MRun && m_rem == 1 && heat && ((m_hc + 1) % TPS) == 0) begin
                ok = 1'b1; break;
            end
            cycle();
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL tickadd_reach got=%0d exp=1", remaining); end
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (remaining !== TW'(10) || finish !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL tickadd got=%0d/%b exp=10/0", remaining, finish);
        end
        pulse(1'b0, 1'b1, 1'b0);
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL tickadd_drain got=busy exp=idle"); end
    endtask

    task automatic test_cancel();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (m_mode == MRun && m_rem == 5) begin ok = 1'b1; break; end
            cycle();
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL cancel_reach got=%0d exp=5", remaining); end
        pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (finish !== 1'b1 || remaining !== '0) begin
            errors++; $display("FAIL cancel_finish got=%b/%0d exp=1/0", finish, remaining);
        end
        cycle();
        checks++;
        if (bell !== 1'b1) begin errors++; $display("FAIL cancel_bell got=%b exp=1", bell); end
        cycle();
        got = {start, finish, busy, remaining};
        checks++;
        if (got !== '0) begin errors++; $display("FAIL cancel_idle got=%h exp=0", got); end
        pulse(1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (start !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL cancel_idle_go got=%b/%b exp=0/0", start, busy);
            end
            cycle();
        end
    endtask

    task automatic test_reset_mid();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (m_mode == MRun && m_rem == 9) begin ok = 1'b1; break; end
            cycle();
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL rstmid_reach got=%0d exp=9", remaining); end
        #2 nrst = 1'b0;
        #1 got = {start, finish, busy, remaining};
        checks++;
        if (got !== '0) begin errors++; $display("FAIL rstmid_async got=%h exp=0", got); end
        @(negedge clk);
        nrst = 1'b1;
        pulse(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (start !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL rstmid_go_ignored got=%b/%b exp=0/0", start, busy);
            end
            cycle();
        end
        pulse(1'b1, 1'b0, 1'b0);
        got = {start, finish, busy, remaining};
        checks++;
        if (got !== {3'b000, TW'(10)}) begin
            errors++; $display("FAIL rstmid_add got=%h exp=%h", got, {3'b000, TW'(10)});
        end
        pulse(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            got = {start, finish, busy, remaining};
            checks++;
            if (got !== exp_vec()) begin
                errors++; $display("FAIL random c=%0d got=%h exp=%h", c, got, exp_vec());
            end
            add_sec = ($urandom_range(0, 7) == 0);
            clr     = ($urandom_range(0, 39) == 0);
            go      = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) door = ~door;
            @(posedge clk);
            @(negedge clk);
        end
        add_sec = 1'b0; clr = 1'b0; go = 1'b0;
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL random_drain got=busy exp=idle"); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_cook();
        test_basic_cook();
        test_pause();
        test_door_open_at_go();
        test_saturation();
        test_tick_add();
        test_cancel();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
